ibex_trace_buffer: RTL and testbench

- Parametrised on-chip capture buffer for RVFI retirement records emitted by the tracing core top.
- Filters retirements by a runtime trace mode, stores them in a Depth-entry FIFO and streams them out over a valid/ready interface.
- Overflow is handled by a compile-time drop policy, with a saturating drop counter and a gap flag.
- Sits beside the tracing top as a synthesizable alternative to the simulation-only text tracer.

---
 rtl/ibex_trace_buffer_pkg.sv | 22 ++
 rtl/ibex_trace_buffer_fifo.sv | 58 +++++
 rtl/ibex_trace_buffer.sv | 126 ++++++++++++
 tb/tb_ibex_trace_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_trace_buffer_pkg.sv
// Shared types for the RVFI retirement trace buffer: trace modes and the stored record layout.
package ibex_trace_buffer_pkg;

  typedef enum logic [1:0] {
    TRACE_OFF  = 2'd0,
    TRACE_ALL  = 2'd1,
    TRACE_FLOW = 2'd2,
    TRACE_TRAP = 2'd3
  } trace_mode_e;

  localparam int unsigned TRACE_REC_W = 103;

  typedef struct packed {
    logic        gap;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] insn;
    logic [31:0] pc;
  } trace_rec_t;

endpackage

// File: rtl/ibex_trace_buffer_fifo.sv
// Generic Depth x Width circular FIFO with flush and overwrite-oldest support.
module ibex_trace_buffer_fifo #(
  parameter int unsigned Depth  = 16,
  parameter int unsigned Width  = 8,
  localparam int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic              overwrite,
  input  logic [Width-1:0]  wdata,
  output logic [Width-1:0]  rdata,
  output logic [LevelW-1:0] level
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rptr;
  logic [PtrW-1:0]  wptr;

  // Storage is not reset; the head is only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      level <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PtrW'(1);
      end
      // Overwrite retires the oldest entry without a consumer pop.
      if (pop || overwrite) begin
        rptr <= rptr + PtrW'(1);
      end
      if (push && !pop && !overwrite) begin
        level <= level + LevelW'(1);
      end else if (pop && !push) begin
        level <= level - LevelW'(1);
      end
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/ibex_trace_buffer.sv
// RVFI retirement capture buffer: mode filter, drop policy, gap marking and valid/ready output.
module ibex_trace_buffer
  import ibex_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth      = 16,
  parameter bit          DropOldest = 1'b0,
  parameter int unsigned DropCntW   = 16,
  localparam int unsigned LevelW    = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          trace_mode_i,
  input  logic                flush_i,
  input  logic                drop_cnt_clr_i,
  input  logic                rvfi_valid_i,
  input  logic [31:0]         rvfi_pc_rdata_i,
  input  logic [31:0]         rvfi_pc_wdata_i,
  input  logic [31:0]         rvfi_insn_i,
  input  logic                rvfi_trap_i,
  input  logic [4:0]          rvfi_rd_addr_i,
  input  logic [31:0]         rvfi_rd_wdata_i,
  output logic                trace_valid_o,
  input  logic                trace_ready_i,
  output trace_rec_t          trace_rec_o,
  output logic [LevelW-1:0]   level_o,
  output logic                full_o,
  output logic [DropCntW-1:0] drop_cnt_o
);

  trace_mode_e         mode_c;
  logic                hit_c;
  logic                push_c;
  logic                pop_c;
  logic                drop_c;
  logic                accept_c;
  logic                overwrite_c;
  logic                valid_c;
  logic                full_c;
  trace_rec_t          wrec_c;
  trace_rec_t          head;
  logic [LevelW-1:0]   level;
  logic [31:0]         prev_pc_q;
  logic                prev_valid_q;
  logic                gap_q;
  logic [DropCntW-1:0] drop_cnt_q;

  assign mode_c = trace_mode_e'(trace_mode_i);

  always_comb begin
    hit_c = 1'b0;
    if (rvfi_valid_i) begin
      case (mode_c)
        TRACE_ALL:  hit_c = 1'b1;
        TRACE_TRAP: hit_c = rvfi_trap_i;
        TRACE_FLOW: hit_c = rvfi_trap_i || !prev_valid_q || (rvfi_pc_rdata_i != prev_pc_q);
        default:    hit_c = 1'b0;
      endcase
    end
  end

  assign valid_c     = (level != '0);
  assign full_c      = (level == LevelW'(Depth));
  assign push_c      = hit_c && !flush_i;
  assign pop_c       = valid_c && trace_ready_i;
  assign drop_c      = push_c && full_c && !pop_c;
  assign accept_c    = push_c && (!drop_c || DropOldest);
  assign overwrite_c = drop_c && DropOldest;

  // With overwrite the displacing record itself carries the gap marker.
  always_comb begin
    wrec_c          = '0;
    wrec_c.gap      = gap_q || drop_c;
    wrec_c.trap     = rvfi_trap_i;
    wrec_c.rd_addr  = rvfi_rd_addr_i;
    wrec_c.rd_wdata = rvfi_rd_wdata_i;
    wrec_c.insn     = rvfi_insn_i;
    wrec_c.pc       = rvfi_pc_rdata_i;
  end

  ibex_trace_buffer_fifo #(
    .Depth (Depth),
    .Width (TRACE_REC_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush_i),
    .push      (accept_c),
    .pop       (pop_c),
    .overwrite (overwrite_c),
    .wdata     (wrec_c),
    .rdata     (head),
    .level     (level)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      gap_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      // Flow tracking follows every retirement, filtered or not.
      if (rvfi_valid_i) begin
        prev_pc_q    <= rvfi_pc_wdata_i;
        prev_valid_q <= 1'b1;
      end
      if (flush_i || accept_c) begin
        gap_q <= 1'b0;
      end else if (drop_c) begin
        gap_q <= 1'b1;
      end
      if (drop_cnt_clr_i) begin
        drop_cnt_q <= drop_c ? DropCntW'(1) : '0;
      end else if (drop_c && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DropCntW'(1);
      end
    end
  end

  assign trace_valid_o = valid_c;
  assign trace_rec_o   = valid_c ? head : '0;
  assign level_o       = level;
  assign full_o        = full_c;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Directed bench for ibex_trace_buffer: table-driven vectors plus overflow, flush and reset sequences.
module tb_ibex_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        flush;
  logic        clr;
  logic        rv;
  logic [31:0] pc;
  logic [31:0] pc_w;
  logic [31:0] insn;
  logic        trap;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        ready;

  logic         valid0, valid1;
  logic [102:0] rec0, rec1;
  logic [4:0]   level0, level1;
  logic         full0, full1;
  logic [15:0]  drop0, drop1;

  int checks = 0;
  int errors = 0;

  ibex_trace_buffer #(.Depth(16), .DropOldest(1'b0), .DropCntW(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .trace_mode_i(mode), .flush_i(flush), .drop_cnt_clr_i(clr),
    .rvfi_valid_i(rv), .rvfi_pc_rdata_i(pc), .rvfi_pc_wdata_i(pc_w), .rvfi_insn_i(insn),
    .rvfi_trap_i(trap), .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(rd_wdata),
    .trace_valid_o(valid0), .trace_ready_i(ready), .trace_rec_o(rec0),
    .level_o(level0), .full_o(full0), .drop_cnt_o(drop0)
  );

  ibex_trace_buffer #(.Depth(16), .DropOldest(1'b1), .DropCntW(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .trace_mode_i(mode), .flush_i(flush), .drop_cnt_clr_i(clr),
    .rvfi_valid_i(rv), .rvfi_pc_rdata_i(pc), .rvfi_pc_wdata_i(pc_w), .rvfi_insn_i(insn),
    .rvfi_trap_i(trap), .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(rd_wdata),
    .trace_valid_o(valid1), .trace_ready_i(ready), .trace_rec_o(rec1),
    .level_o(level1), .full_o(full1), .drop_cnt_o(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic        rv;
    logic [31:0] pc;
    logic        trap;
    logic        ready;
    logic        flush;
    logic        ev;
    logic [31:0] epc;
    logic        etrap;
    logic [4:0]  elevel;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [102:0] mk_rec(input logic g, input logic t, input logic [31:0] p);
    return {g, t, p[6:2], ~p, p ^ 32'h0000_0013, p};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic v, input logic [31:0] p, input logic t,
                       input logic rdy, input logic fl, input logic cl);
    mode     = m;
    rv       = v;
    pc       = p;
    pc_w     = p + 32'd4;
    insn     = p ^ 32'h0000_0013;
    trap     = t;
    rd_addr  = p[6:2];
    rd_wdata = ~p;
    ready    = rdy;
    flush    = fl;
    clr      = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      drive(2'd1, 1'b1, base + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(2'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //           rst   mode rv    pc           trap  rdy   flush ev    epc          etrap lvl
    vecs[0]  = '{1'b0, 2'd1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 5'd1};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 5'd1};
    vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 5'd1};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0};
    vecs[5]  = '{1'b0, 2'd2, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 5'd1};
    vecs[6]  = '{1'b0, 2'd2, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0};
    vecs[7]  = '{1'b0, 2'd2, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 5'd1};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0};
    vecs[9]  = '{1'b0, 2'd3, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0};
    vecs[10] = '{1'b0, 2'd3, 1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 1'b1, 32'h304, 1'b1, 5'd1};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h308, 1'b1, 1'b0, 1'b0, 1'b1, 32'h304, 1'b1, 5'd1};
    vecs[12] = '{1'b0, 2'd2, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1, 32'h304, 1'b1, 5'd2};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 5'd1};
    vecs[14] = '{1'b0, 2'd1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 5'd0};
    vecs[15] = '{1'b0, 2'd1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 5'd0};

    // Reset state
    drive(2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    check("reset valid", 128'(valid0), 128'(1'b0));
    check("reset level", 128'(level0), 128'(5'd0));
    check("reset full", 128'(full0), 128'(1'b0));
    check("reset drop", 128'(drop0), 128'(16'd0));
    check("reset rec", 128'(rec0), 128'(103'd0));
    rst_n = 1'b1;

    // Table-driven single-cycle vectors against the DropOldest=0 instance
    for (int i = 0; i < 16; i++) begin
      rst_n = !vecs[i].rst;
      drive(vecs[i].mode, vecs[i].rv, vecs[i].pc, vecs[i].trap, vecs[i].ready, vecs[i].flush, 1'b0);
      tick();
      rst_n = 1'b1;
      check($sformatf("vec%0d valid", i), 128'(valid0), 128'(vecs[i].ev));
      check($sformatf("vec%0d rec", i), 128'(rec0),
            vecs[i].ev ? 128'(mk_rec(1'b0, vecs[i].etrap, vecs[i].epc)) : 128'(103'd0));
      check($sformatf("vec%0d level", i), 128'(level0), 128'(vecs[i].elevel));
      check($sformatf("vec%0d drop", i), 128'(drop0), 128'(16'd0));
    end

    // Overflow by two with ready low: drop-new vs drop-oldest
    do_reset();
    fill(18, 32'h1000);
    check("ovf level0", 128'(level0), 128'(5'd16));
    check("ovf full0", 128'(full0), 128'(1'b1));
    check("ovf drop0", 128'(drop0), 128'(16'd2));
    check("ovf level1", 128'(level1), 128'(5'd16));
    check("ovf full1", 128'(full1), 128'(1'b1));
    check("ovf drop1", 128'(drop1), 128'(16'd2));
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d rec0", k), 128'(rec0), 128'(mk_rec(1'b0, 1'b0, 32'h1000 + 32'(4 * k))));
      check($sformatf("drain%0d rec1", k), 128'(rec1),
            128'(mk_rec(k >= 14, 1'b0, 32'h1008 + 32'(4 * k))));
      drive(2'd1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("drained valid0", 128'(valid0), 128'(1'b0));
    check("drained valid1", 128'(valid1), 128'(1'b0));
    drive(2'd1, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(2'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gap rec0", 128'(rec0), 128'(mk_rec(1'b1, 1'b0, 32'h2000)));
    check("gap rec1", 128'(rec1), 128'(mk_rec(1'b0, 1'b0, 32'h2000)));

    // Full with simultaneous push and pop
    do_reset();
    fill(16, 32'h3000);
    drive(2'd1, 1'b1, 32'h3040, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("pushpop level0", 128'(level0), 128'(5'd16));
    check("pushpop drop0", 128'(drop0), 128'(16'd0));
    check("pushpop rec0", 128'(rec0), 128'(mk_rec(1'b0, 1'b0, 32'h3004)));
    check("pushpop level1", 128'(level1), 128'(5'd16));
    check("pushpop drop1", 128'(drop1), 128'(16'd0));

    // Clear coincident with a drop leaves one counted
    drive(2'd1, 1'b1, 32'h3044, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("clr+drop drop0", 128'(drop0), 128'(16'd1));
    check("clr+drop drop1", 128'(drop1), 128'(16'd1));
    drive(2'd1, 1'b1, 32'h3048, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("drop2 drop0", 128'(drop0), 128'(16'd2));
    drive(2'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("clr drop0", 128'(drop0), 128'(16'd0));
    check("clr drop1", 128'(drop1), 128'(16'd0));

    // Flush together with a TRAP hit at level 5
    do_reset();
    fill(5, 32'h5000);
    check("pre-flush level", 128'(level0), 128'(5'd5));
    drive(2'd3, 1'b1, 32'h6000, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(2'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush level0", 128'(level0), 128'(5'd0));
    check("flush valid0", 128'(valid0), 128'(1'b0));
    check("flush rec0", 128'(rec0), 128'(103'd0));
    check("flush drop0", 128'(drop0), 128'(16'd0));
    check("flush level1", 128'(level1), 128'(5'd0));

    // Reset mid-stream
    fill(3, 32'h7000);
    check("pre-rst level", 128'(level0), 128'(5'd3));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst valid", 128'(valid0), 128'(1'b0));
    check("midrst level", 128'(level0), 128'(5'd0));
    check("midrst rec", 128'(rec0), 128'(103'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
